// File: rtl/memtest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memtest_pkg
// Description : Shared constants for the memory-test read-back checker:
//               checker state encodings, datapath widths and the helper
//               that builds a 64-bit expected beat from the PRNG word.
// Revision    : 1.0 - initial release
// ============================================================================
package memtest_pkg;

  localparam int DATA_W     = 64;
  localparam int PRNG_W     = 20;
  localparam int BEAT_CNT_W = 19;

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SEED  = 3'd1;
  localparam logic [2:0] c_PRIME = 3'd2;
  localparam logic [2:0] c_RUN   = 3'd3;
  localparam logic [2:0] c_FIN   = 3'd4;

  // The low 16 PRNG bits are replicated across all four lanes of the beat.
  function automatic logic [DATA_W-1:0] expected_beat(input logic [15:0] r);
    return {4{r}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/memtest_prng20.sv
`default_nettype none
// ============================================================================
// Module      : memtest_prng20
// Description : 20-bit XNOR-feedback PRNG. Each ce strobe runs twenty shift
//               iterations and registers the twenty feedback bits as rand_o.
// Revision    : 1.0 - initial release
// ============================================================================
module memtest_prng20
  import memtest_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  output logic [PRNG_W-1:0] rand_o
);

  logic [PRNG_W-1:0] s_q;
  logic [PRNG_W-1:0] s_d;
  logic [PRNG_W-1:0] rand_q;
  logic [PRNG_W-1:0] rand_d;

  // Unrolled twenty-step advance; feedback bit i becomes output bit i.
  always_comb begin
    s_d    = s_q;
    rand_d = rand_q;
    if (ce) begin
      for (int i = 0; i < PRNG_W; i++) begin
        rand_d[i] = ~(s_d[19] ^ s_d[16]);
        s_d       = {s_d[18:0], rand_d[i]};
      end
    end
  end

  // State and output word registers; reset returns both to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      rand_q <= '0;
    end else begin
      s_q    <= s_d;
      rand_q <= rand_d;
    end
  end

  assign rand_o = rand_q;

endmodule
`default_nettype wire

// File: rtl/memtest_checker.sv
`default_nettype none
// ============================================================================
// Module      : memtest_checker
// Description : Memory-test read-back checker. Regenerates the pseudo-random
//               pattern written to memory and counts mismatching beats over
//               nbursts*BURST_LEN beats, with a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module memtest_checker
  import memtest_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       nbursts,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              dat_valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count
);

  localparam int BL_SHIFT = $clog2(BURST_LEN);

  logic [2:0]            state_q;
  logic [2:0]            state_d;
  logic [15:0]           nb_q;
  logic [BEAT_CNT_W-1:0] beat_q;
  logic [CNT_W-1:0]      err_q;

  logic [PRNG_W-1:0]     w_rand;
  logic [BEAT_CNT_W-1:0] w_last_beat;
  logic                  w_accept;
  logic                  w_mismatch;
  logic                  w_prng_rst;
  logic                  w_prng_ce;
  logic                  w_unused_rand;

  // Index of the final beat of the run; only meaningful when nb_q is nonzero.
  assign w_last_beat = ({3'b000, nb_q} << BL_SHIFT) - {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
  assign w_accept    = (state_q == c_RUN) && dat_valid;
  assign w_mismatch  = (dat_i != expected_beat(w_rand[15:0]));
  assign w_prng_rst  = rst || (state_q == c_SEED);
  assign w_prng_ce   = (state_q == c_PRIME) || w_accept;

  // Upper PRNG bits feed only the shift chain, not the expected beat.
  assign w_unused_rand = ^w_rand[PRNG_W-1:16];

  memtest_prng20 u_prng (
    .clk    (clk),
    .rst    (w_prng_rst),
    .ce     (w_prng_ce),
    .rand_o (w_rand)
  );

  // Run sequencing: seed the PRNG, prime the first word, check, report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (start) state_d = c_SEED;
      c_SEED:  state_d = c_PRIME;
      c_PRIME: state_d = (nb_q == 16'd0) ? c_FIN : c_RUN;
      c_RUN:   if (w_accept && (beat_q == w_last_beat)) state_d = c_FIN;
      c_FIN:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // State, run length, beat counter and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      nb_q    <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == c_IDLE) && start) begin
        nb_q   <= nbursts;
        beat_q <= '0;
        err_q  <= '0;
      end else if (w_accept) begin
        beat_q <= beat_q + {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
        if (w_mismatch && !(&err_q)) begin
          err_q <= err_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign ready     = (state_q == c_RUN);
  assign busy      = (state_q != c_IDLE);
  assign done      = (state_q == c_FIN);
  assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_memtest_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_memtest_checker
// Description : Scoreboard bench for memtest_checker. Stimulus tasks compute
//               the expected error count for each run from a bit-serial
//               reference PRNG and queue it; a monitor pops on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memtest_checker;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] nbursts = '0;
  logic [63:0] dat_i = '0;
  logic        dat_valid = 1'b0;
  logic        ready, busy, done;
  logic [31:0] err_count;

  logic        start2 = 1'b0;
  logic [15:0] nbursts2 = '0;
  logic [63:0] dat2 = '0;
  logic        valid2 = 1'b0;
  logic        ready2, busy2, done2;
  logic [1:0]  err2;

  int nvec  = 0;
  int nfail = 0;
  int exp_q[$];

  memtest_checker #(.BURST_LEN(BL), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .nbursts(nbursts),
    .dat_i(dat_i), .dat_valid(dat_valid), .ready(ready), .busy(busy),
    .done(done), .err_count(err_count)
  );

  memtest_checker #(.BURST_LEN(BL), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .nbursts(nbursts2),
    .dat_i(dat2), .dat_valid(valid2), .ready(ready2), .busy(busy2),
    .done(done2), .err_count(err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference generator: one 20-bit output word per call, built bit by bit.
  function automatic int unsigned prng_next(input int unsigned st_in, output int unsigned st_out);
    int unsigned st;
    int unsigned r;
    int unsigned fb;
    st = st_in;
    r  = 0;
    for (int i = 0; i < 20; i++) begin
      fb = (((st >> 19) ^ (st >> 16)) & 1) ^ 1;
      r  = r | (fb << i);
      st = ((st << 1) | fb) & 32'hFFFFF;
    end
    st_out = st;
    return r;
  endfunction

  function automatic logic [63:0] mk_word(input int unsigned r);
    logic [15:0] h;
    h = r[15:0];
    return {h, h, h, h};
  endfunction

  // Monitor: each done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        chk("err_count_at_done", 64'(err_count), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic run(input int nb, input int bad_pct, input bit gaps,
                     input bit midstart, input bit lit0, input bit zero0);
    logic [63:0]  beats[$];
    logic [63:0]  w;
    logic [63:0]  v;
    logic [63:0]  x;
    int unsigned  st;
    int unsigned  st_n;
    int unsigned  r;
    int           total;
    int           nerr;
    int           i;
    int           cyc;
    int           lat;
    bit           got;
    bit           saw_ready;
    bit           idle_next;
    bit           pulsed;
    total = nb * BL;
    nerr  = 0;
    st    = 0;
    for (int k = 0; k < total; k++) begin
      r  = prng_next(st, st_n);
      st = st_n;
      w  = mk_word(r);
      v  = w;
      if (k == 0 && lit0) v = 64'hFFFF_FFFF_FFFF_FFFF;
      else if (k == 0 && zero0) v = 64'h0;
      else if (int'($urandom_range(99)) < bad_pct) begin
        x = {$urandom, $urandom};
        if (x == 64'd0) x = 64'd1;
        v = w ^ x;
      end
      if (v !== w) nerr++;
      beats.push_back(v);
    end
    exp_q.push_back(nerr);

    start = 1'b1; nbursts = 16'(nb);
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; cyc = 0; idle_next = 1'b0; pulsed = 1'b0;
    while (i < total && cyc < 200 + total * 4) begin
      start = 1'b0;
      if (midstart && !pulsed && i == 3) begin
        start = 1'b1; nbursts = 16'd0; pulsed = 1'b1;
      end
      dat_valid = !(idle_next || (gaps && $urandom_range(3) == 0));
      dat_i     = dat_valid ? beats[i] : {$urandom, $urandom};
      @(negedge clk);
      idle_next = 1'b0;
      if (ready && dat_valid) begin
        i++;
        idle_next = gaps;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dat_valid = 1'b0;
    start = 1'b0;
    if (i < total) chk("beats_accepted", 64'(i), 64'(total));

    got = 1'b0; lat = -1; saw_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!got) begin
        @(negedge clk);
        if (done) begin got = 1'b1; lat = k; end
        else if (ready) saw_ready = 1'b1;
      end
    end
    chk("done_latency", 64'(lat), (total == 0) ? 64'd2 : 64'd0);
    if (!got) exp_q.delete();
    if (total == 0) chk("ready_when_empty", 64'(saw_ready), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {62'd0, done, busy}, 64'd0);
  endtask

  task automatic reset_midrun();
    int unsigned st;
    int unsigned st_n;
    int unsigned r;
    logic [63:0] w;
    int acc;
    int cyc;
    st = 0; acc = 0; cyc = 0;
    start = 1'b1; nbursts = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    r = prng_next(st, st_n); st = st_n; w = mk_word(r);
    while (acc < 2 && cyc < 50) begin
      dat_valid = 1'b1; dat_i = ~w;
      @(negedge clk);
      if (ready) begin
        acc++;
        r = prng_next(st, st_n); st = st_n; w = mk_word(r);
      end
      @(posedge clk); #1;
      cyc++;
    end
    dat_valid = 1'b0;
    @(negedge clk);
    chk("err_before_reset", 64'(err_count), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    repeat (4) @(negedge clk);
    chk("rst_stays_idle", {62'd0, busy, done}, 64'd0);
  endtask

  task automatic saturate();
    int unsigned st;
    int unsigned st_n;
    int unsigned r;
    logic [63:0] w;
    int acc;
    int cyc;
    bit got;
    st = 0; acc = 0; cyc = 0; got = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1; nbursts2 = 16'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    r = prng_next(st, st_n); st = st_n; w = mk_word(r);
    while (!got && cyc < 60) begin
      valid2 = (acc < BL); dat2 = ~w;
      @(negedge clk);
      if (done2) begin
        got = 1'b1;
        chk("sat_err_count", 64'(err2), 64'd3);
      end
      if (ready2 && valid2) begin
        acc++;
        r = prng_next(st, st_n); st = st_n; w = mk_word(r);
      end
      @(posedge clk); #1;
      cyc++;
    end
    valid2 = 1'b0;
    if (!got) chk("sat_done_seen", 64'(got), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(2, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    saturate();
    reset_midrun();
    run(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      run(int'($urandom_range(6)), int'($urandom_range(60)), 1'($urandom_range(1)),
          1'b0, 1'b0, 1'b0);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memtest_checker.md
MEMTEST_CHECKER -- requirements
Module: memtest_checker

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning data beats per burst (power of two, 1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the error counter.
REQ-003 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a check run.
REQ-006 SHALL have port nbursts  input  16  number of bursts to check, sampled with start.
REQ-007 SHALL have port dat_i  input  64  read-back data beat.
REQ-008 SHALL have port dat_valid  input  1  dat_i holds a valid beat.
REQ-009 SHALL have port ready  output  1  checker accepts a beat this cycle.
REQ-010 SHALL have port busy  output  1  a run is in progress.
REQ-011 SHALL have port done  output  1  single-cycle end-of-run pulse.
REQ-012 SHALL have port err_count  output  CNT_W  count of mismatching beats in the current or last run.

Function
REQ-013 SHALL regenerate expected data with a 20-bit PRNG: per advance, 20 iterations of o = NOT(s[19] XOR s[16]), rand[i] = o, s = {s[18:0], o}; rand is registered; PRNG reset sets s = 0 and rand = 0.
REQ-014 SHALL form the expected beat as {4{rand[15:0]}}.
REQ-015 SHALL use states IDLE, SEED, PRIME, RUN, FIN.
REQ-016 IDLE: start=1 latches nbursts, clears err_count and the beat counter, and moves to SEED; start in any other state is ignored.
REQ-017 SEED: resets the PRNG for one cycle, then moves to PRIME.
REQ-018 PRIME: advances the PRNG once; moves to FIN if latched nbursts = 0, else to RUN.
REQ-019 RUN: ready=1; a beat is accepted when dat_valid=1; gaps in dat_valid stall without consequence.
REQ-020 Each accepted beat SHALL be compared with the expected beat.
REQ-021 Each accepted beat SHALL increment err_count on the same edge if it mismatches.
REQ-022 Each accepted beat SHALL advance the PRNG on the same edge, so the next beat's expectation is valid next cycle.
REQ-023 RUN SHALL move to FIN on acceptance of beat number nbursts*BURST_LEN-1 (counter width 19 bits).
REQ-024 FIN: done=1 for exactly one cycle with the final err_count, then IDLE.
REQ-025 err_count SHALL saturate at all-ones.
REQ-026 err_count SHALL hold its value in IDLE until the next accepted start.
REQ-027 ready SHALL be 0 outside RUN.
REQ-028 dat_valid SHALL be ignored outside RUN.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Start-to-done latency for nbursts=0 SHALL be 3 cycles (start at edge 0, done high in cycle 3).

Reset
REQ-031 rst SHALL force IDLE, ready=0, busy=0, done=0, err_count=0, beat counter=0, PRNG state and rand = 0, including mid-run, with no done pulse.

Structure
REQ-032 State encodings and the expected-word construction width (64) SHALL live in a shared memtest package.
REQ-033 The PRNG SHALL be a separate sub-module memtest_prng20 (clk, rst, ce, rand[19:0]), driven by the checker's SEED reset and advance strobes.

Verification
REQ-034 start with nbursts=0 -> done pulse 3 cycles later, err_count=0, no ready.
REQ-035 start with nbursts=1, BURST_LEN=4, correct regenerated beats back-to-back -> first expected beat 64'hFFFF_FFFF_FFFF_FFFF, done one cycle after fourth beat, err_count=0.
REQ-036 As REQ-035 but beat 0 driven as 64'h0 -> err_count=1 at done.
REQ-037 nbursts=2 with one idle dat_valid cycle between every beat -> 8 beats accepted, err_count=0; a start pulse mid-run is ignored.
REQ-038 CNT_W=2, nbursts=1, all beats wrong -> err_count saturates at 3.
REQ-039 rst asserted after 2 of 4 beats -> next cycle IDLE, busy=0, err_count=0, no done; a fresh run then passes with err_count=0.
